regfile_mp: RTL

- Parametrised multi-port register file: the successor to the single-write, two-read ARM register file.
- Adds a third read port, a second write port for base-register writeback (LDR/STR pre/post-index), optional write-to-read bypass, and a per-register busy scoreboard for hazard detection.
- Sits between decode and execute in the pipelined core; the top index always reads the externally supplied PC value (R15).

---
 rtl/regfile_mp_if.sv | 56 +++++
 rtl/regfile_mp.sv | 106 ++++++++++
 2 files changed

// File: rtl/regfile_mp_if.sv
// Register file bus: three read ports with busy flags, two write ports,
// the scoreboard set request and the externally supplied PC value.
interface regfile_mp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    // Read ports
    logic [ADDR_WIDTH-1:0] A1;
    logic [ADDR_WIDTH-1:0] A2;
    logic [ADDR_WIDTH-1:0] A4;
    logic [DATA_WIDTH-1:0] RD1;
    logic [DATA_WIDTH-1:0] RD2;
    logic [DATA_WIDTH-1:0] RD4;
    logic                  BUSY1;
    logic                  BUSY2;
    logic                  BUSY4;

    // Primary write port
    logic                  WE3;
    logic [ADDR_WIDTH-1:0] A3;
    logic [DATA_WIDTH-1:0] WD3;

    // Secondary (base writeback) write port
    logic                  WE5;
    logic [ADDR_WIDTH-1:0] A5;
    logic [DATA_WIDTH-1:0] WD5;

    // Scoreboard set request
    logic                  SETB;
    logic [ADDR_WIDTH-1:0] ASB;

    // PC alias returned for the top register index
    logic [DATA_WIDTH-1:0] R15;

    // Pipeline side: drives addresses, writes and PC; receives read data
    modport master (
        output A1, A2, A4,
        output WE3, A3, WD3,
        output WE5, A5, WD5,
        output SETB, ASB,
        output R15,
        input  RD1, RD2, RD4,
        input  BUSY1, BUSY2, BUSY4
    );

    // Register file side
    modport slave (
        input  A1, A2, A4,
        input  WE3, A3, WD3,
        input  WE5, A5, WD5,
        input  SETB, ASB,
        input  R15,
        output RD1, RD2, RD4,
        output BUSY1, BUSY2, BUSY4
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: three combinational read ports, a primary and a
// base-writeback write port, optional write-to-read forwarding and a busy
// scoreboard. The top index is not stored; it aliases the external PC input.
module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter bit BYPASS     = 1'b1
) (
    input  logic         CLK,
    input  logic         RESETn,
    regfile_mp_if.slave  bus
);
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;
    localparam int NUM_STORED = NUM_REGS - 1;
    localparam int NUM_READ   = 3;
    localparam logic [ADDR_WIDTH-1:0] TOP_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

    // Architectural state: general registers and their busy bits
    logic [DATA_WIDTH-1:0] data_reg [NUM_STORED];
    logic [NUM_STORED-1:0] busy_reg;

    // Per-register decode of this cycle's write and busy-set requests
    logic [NUM_STORED-1:0] wr3_hit;
    logic [NUM_STORED-1:0] wr5_hit;
    logic [NUM_STORED-1:0] setb_hit;

    // Read ports gathered into arrays so they share one lookup loop
    logic [ADDR_WIDTH-1:0] rd_addr [NUM_READ];
    logic [DATA_WIDTH-1:0] rd_data [NUM_READ];
    logic                  rd_busy [NUM_READ];

    // Enables gate the address compare so an undriven address with the
    // enable low can never select a register.
    generate
        for (genvar gi = 0; gi < NUM_STORED; gi++) begin : g_decode
            assign wr3_hit[gi]  = bus.WE3  && (bus.A3  == ADDR_WIDTH'(gi));
            assign wr5_hit[gi]  = bus.WE5  && (bus.A5  == ADDR_WIDTH'(gi));
            assign setb_hit[gi] = bus.SETB && (bus.ASB == ADDR_WIDTH'(gi));
        end
    endgenerate

    // Register data update; port 3 takes priority over port 5 on a collision
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            for (int i = 0; i < NUM_STORED; i++) begin
                data_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_STORED; i++) begin
                if (wr3_hit[i]) begin
                    data_reg[i] <= bus.WD3;
                end else if (wr5_hit[i]) begin
                    data_reg[i] <= bus.WD5;
                end
            end
        end
    end

    // Scoreboard update; a new producer (SETB) outranks a retiring write
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            busy_reg <= '0;
        end else begin
            for (int i = 0; i < NUM_STORED; i++) begin
                if (setb_hit[i]) begin
                    busy_reg[i] <= 1'b1;
                end else if (wr3_hit[i] || wr5_hit[i]) begin
                    busy_reg[i] <= 1'b0;
                end
            end
        end
    end

    assign rd_addr[0] = bus.A1;
    assign rd_addr[1] = bus.A2;
    assign rd_addr[2] = bus.A4;

    // Read lookup: PC alias, then forwarded write data, then stored value
    always_comb begin
        for (int p = 0; p < NUM_READ; p++) begin
            rd_data[p] = '0;
            rd_busy[p] = 1'b0;
            if (rd_addr[p] == TOP_ADDR) begin
                rd_data[p] = bus.R15;
                rd_busy[p] = 1'b0;
            end else if (BYPASS && bus.WE3 && (bus.A3 == rd_addr[p])) begin
                rd_data[p] = bus.WD3;
                rd_busy[p] = 1'b0;
            end else if (BYPASS && bus.WE5 && (bus.A5 == rd_addr[p])) begin
                rd_data[p] = bus.WD5;
                rd_busy[p] = 1'b0;
            end else begin
                rd_data[p] = data_reg[rd_addr[p]];
                rd_busy[p] = busy_reg[rd_addr[p]];
            end
        end
    end

    assign bus.RD1   = rd_data[0];
    assign bus.RD2   = rd_data[1];
    assign bus.RD4   = rd_data[2];
    assign bus.BUSY1 = rd_busy[0];
    assign bus.BUSY2 = rd_busy[1];
    assign bus.BUSY4 = rd_busy[2];

endmodule
